param_stack: RTL and testbench
==============================

Name: param_stack

Overview:
- Parametrised LIFO stack. Successor to the fixed 8-bit stack, which used a shared bidirectional data bus and a single push_pop mode bit.
- Generalised in data width and depth. Separate push/pop strobes and split read/write buses.
- Adds same-cycle push+pop (swap or pass-through), combinational peek, fill level, almost-full, sticky error flags and synchronous clear.
- Used as an operand/return-address stack by datapath blocks in the same clock domain.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 1024, number of entries; any value >= 2.
- AF_MARGIN, 4, almost_full asserts when count >= DEPTH - AF_MARGIN; must be < DEPTH.
- CW, $clog2(DEPTH+1), derived width of count/level (localparam).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-low. Asserts immediately; deasserts synchronously to clk externally.
- enable  in  1  qualifies push/pop/clear; when 0, all state holds.
- clear  in  1  synchronous flush when enable=1.
- push  in  1  write data_in onto stack.
- pop  in  1  remove top entry into data_out.
- data_in  in  WIDTH  write data.
- data_out  out  WIDTH  registered pop data.
- rd_valid  out  1  one-cycle pulse: data_out updated this cycle.
- top_data  out  WIDTH  combinational peek of mem[count-1]; 0 when empty.
- count  out  CW  current number of entries, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- almost_full  out  1  count >= DEPTH-AF_MARGIN.
- overflow  out  1  sticky: push attempted while full (no swap).
- underflow  out  1  sticky: pop attempted while empty (no push).
- max_level  out  CW  high-water mark (see Optional Feature).

Behaviour:
- Reset (rst=0, async):
  - count=0, data_out=0, rd_valid=0, overflow=0, underflow=0, max_level=0.
  - Therefore empty=1, full=0, almost_full=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all entries; the next cycle after release behaves as empty.
- enable=0: no state change; rd_valid=0 next cycle; inputs ignored.
- Priority when enable=1: clear > push/pop.
- clear=1: count<=0, overflow<=0, underflow<=0, max_level<=0, rd_valid<=0. data_out holds. push/pop are ignored.
- Push only:
  - If !full: mem[count]<=data_in, count<=count+1.
  - If full: no write, count holds, overflow<=1.
- Pop only:
  - If !empty: data_out<=mem[count-1], rd_valid<=1, count<=count-1.
  - If empty: underflow<=1, rd_valid<=0, data_out holds.
- Push and pop together:
  - Not empty (including full): swap. data_out<=mem[count-1], mem[count-1]<=data_in, rd_valid<=1, count unchanged. No error flags.
  - Empty: pass-through. data_out<=data_in, rd_valid<=1, count stays 0. No error flags.
- Latency:
  - Pop data valid one clock after the pop edge (rd_valid high for exactly that cycle).
  - Pushed data is visible on top_data in the cycle after the push edge.
- rd_valid is 0 in any cycle not following a successful pop, swap or pass-through.
- Flags are derived combinationally from count. overflow/underflow are cleared only by rst or clear.
- Pointer arithmetic uses CW bits. Memory index is count-1 or count, truncated to $clog2(DEPTH) bits. No wrap: count saturates at 0 and DEPTH by the rules above.

Optional Feature:
- Macro: PARAM_STACK_WATERMARK_EN.
- Defined: max_level tracks the maximum count reached since the last rst or clear. It updates the cycle after count exceeds it.
- Undefined: max_level is tied to 0 and no watermark register is synthesised. All other behaviour is identical.

Test Plan:
- Reset then fill: push 0,2,4,...,2*(DEPTH-1) with DEPTH=1024 -> count=1024, full=1, almost_full from count 1020, top_data=2046, overflow=0.
- Drain: pop 1024 times -> data_out sequence 2046,2044,...,0, each with a one-cycle rd_valid; then empty=1, count=0. An extra pop sets underflow=1 and rd_valid stays 0.
- Overflow/swap at full: push 8'hAA when full -> overflow=1, count=1024. Then push+pop with 8'h55 -> data_out=2046, top_data=8'h55, count=1024.
- Pass-through: empty stack, push+pop with 8'h3C -> rd_valid=1, data_out=8'h3C, count=0, underflow=0.
- Clear/reset mid-run: push 10 words, clear=1 -> count=0, flags=0. Push 3 words, drop rst low mid-cycle -> count=0 and empty=1 immediately, without waiting for a clock edge.
- Watermark (macro defined): push 7, pop 4, push 2 -> max_level=7. With the macro undefined -> max_level=0 throughout.

Source files
------------

// File: rtl/param_stack.sv
// Parametrised LIFO stack with same-cycle swap/pass-through, peek, fill level and sticky error flags.
// Optional high-water mark register enabled by defining PARAM_STACK_WATERMARK_EN.
module param_stack #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 1024,
    parameter int AF_MARGIN = 4,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             rd_valid,
    output logic [WIDTH-1:0] top_data,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             overflow,
    output logic             underflow,
    output logic [CW-1:0]    max_level
);

    localparam int AW = $clog2(DEPTH);

    // Handshake: push/pop are single-cycle strobes qualified by enable, with no
    // back-pressure; callers watch full/empty, and rd_valid marks data_out for one cycle.

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_m1;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;
    logic [WIDTH-1:0] data_out_r;
    logic             rd_valid_r;
    logic             ovf_r;
    logic             unf_r;
    logic             is_empty;
    logic             is_full;
    logic             mem_we;
    logic [AW-1:0]    mem_idx;

    assign count_m1 = count_r - CW'(1);
    assign top_idx  = count_m1[AW-1:0];
    assign wr_idx   = count_r[AW-1:0];
    assign is_empty = (count_r == '0);
    assign is_full  = (count_r == CW'(DEPTH));

    // A swap overwrites the current top; a plain push writes one slot above it.
    always_comb begin
        mem_we  = 1'b0;
        mem_idx = wr_idx;
        if (enable && !clear && push) begin
            if (pop) begin
                mem_we  = !is_empty;
                mem_idx = top_idx;
            end else begin
                mem_we  = !is_full;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r    <= '0;
            data_out_r <= '0;
            rd_valid_r <= 1'b0;
            ovf_r      <= 1'b0;
            unf_r      <= 1'b0;
        end else begin
            rd_valid_r <= 1'b0;
            if (enable) begin
                if (clear) begin
                    count_r <= '0;
                    ovf_r   <= 1'b0;
                    unf_r   <= 1'b0;
                end else if (push && pop) begin
                    rd_valid_r <= 1'b1;
                    data_out_r <= is_empty ? data_in : mem[top_idx];
                end else if (push) begin
                    if (is_full) begin
                        ovf_r <= 1'b1;
                    end else begin
                        count_r <= count_r + CW'(1);
                    end
                end else if (pop) begin
                    if (is_empty) begin
                        unf_r <= 1'b1;
                    end else begin
                        data_out_r <= mem[top_idx];
                        rd_valid_r <= 1'b1;
                        count_r    <= count_m1;
                    end
                end
            end
        end
    end

`ifdef PARAM_STACK_WATERMARK_EN
    logic [CW-1:0] max_r;

    // Follows count one cycle late; frozen along with everything else while enable is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_r <= '0;
        end else if (enable) begin
            if (clear) begin
                max_r <= '0;
            end else if (count_r > max_r) begin
                max_r <= count_r;
            end
        end
    end

    assign max_level = max_r;
`else
    assign max_level = '0;
`endif

    assign data_out    = data_out_r;
    assign rd_valid    = rd_valid_r;
    assign top_data    = is_empty ? '0 : mem[top_idx];
    assign count       = count_r;
    assign empty       = is_empty;
    assign full        = is_full;
    assign almost_full = (count_r >= CW'(DEPTH - AF_MARGIN));
    assign overflow    = ovf_r;
    assign underflow   = unf_r;

endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack: fill/drain, overflow/underflow, swap, pass-through,
// clear, asynchronous reset mid-cycle and the high-water mark.
module tb_param_stack;

    localparam int W  = 12;
    localparam int D  = 1024;
    localparam int AF = 4;
    localparam int CW = $clog2(D + 1);

`ifdef PARAM_STACK_WATERMARK_EN
    localparam bit WM_EN = 1'b1;
`else
    localparam bit WM_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          enable;
    logic          clear;
    logic          push;
    logic          pop;
    logic [W-1:0]  data_in;
    logic [W-1:0]  data_out;
    logic          rd_valid;
    logic [W-1:0]  top_data;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic          overflow;
    logic          underflow;
    logic [CW-1:0] max_level;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v;

    param_stack #(.WIDTH(W), .DEPTH(D), .AF_MARGIN(AF)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .push(push), .pop(pop),
        .data_in(data_in), .data_out(data_out), .rd_valid(rd_valid), .top_data(top_data),
        .count(count), .empty(empty), .full(full), .almost_full(almost_full),
        .overflow(overflow), .underflow(underflow), .max_level(max_level)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One enabled clock with the given strobes; returns 1 time unit after the edge.
    task automatic drive(input logic p, input logic q, input logic c, input logic [W-1:0] d);
        enable  = 1'b1;
        push    = p;
        pop     = q;
        clear   = c;
        data_in = d;
        @(posedge clk);
        #1;
        enable = 1'b0;
        push   = 1'b0;
        pop    = 1'b0;
        clear  = 1'b0;
    endtask

    task automatic do_push(input logic [W-1:0] d);
        drive(1'b1, 1'b0, 1'b0, d);
        exp_q.push_back(d);
    endtask

    task automatic do_pop(input string tag);
        drive(1'b0, 1'b1, 1'b0, '0);
        exp_v = exp_q.pop_back();
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check({tag, "_data"}, 32'(data_out), 32'(exp_v));
    endtask

    initial begin
        rst     = 1'b0;
        enable  = 1'b0;
        clear   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_af", 32'(almost_full), 32'd0);
        check("rst_rdv", 32'(rd_valid), 32'd0);
        check("rst_dout", 32'(data_out), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_unf", 32'(underflow), 32'd0);
        check("rst_max", 32'(max_level), 32'd0);
        check("rst_top", 32'(top_data), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // fill 0,2,..,2046
        for (int i = 0; i < D; i++) begin
            do_push(W'(2 * i));
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_af", 32'(almost_full), 32'((i + 1) >= 1020));
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_top", 32'(top_data), 32'd2046);
        check("fill_ovf", 32'(overflow), 32'd0);

        // drain 2046..0
        for (int i = 0; i < D; i++) begin
            do_pop("drain");
        end
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_count", 32'(count), 32'd0);
        drive(1'b0, 1'b1, 1'b0, '0);
        check("unf_flag", 32'(underflow), 32'd1);
        check("unf_rdv", 32'(rd_valid), 32'd0);
        check("unf_dout", 32'(data_out), 32'd0);

        // refill, then overflow and swap at full
        for (int i = 0; i < D; i++) begin
            do_push(W'(2 * i));
        end
        drive(1'b1, 1'b0, 1'b0, W'(8'hAA));
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd1024);
        check("ovf_top", 32'(top_data), 32'd2046);
        check("ovf_unf_sticky", 32'(underflow), 32'd1);
        check("wm_full", 32'(max_level), WM_EN ? 32'd1024 : 32'd0);
        drive(1'b1, 1'b1, 1'b0, W'(8'h55));
        exp_v = exp_q.pop_back();
        exp_q.push_back(W'(8'h55));
        check("swap_rdv", 32'(rd_valid), 32'd1);
        check("swap_dout", 32'(data_out), 32'(exp_v));
        check("swap_top", 32'(top_data), 32'h55);
        check("swap_count", 32'(count), 32'd1024);
        check("swap_ovf", 32'(overflow), 32'd1);

        // clear from full: data_out holds
        drive(1'b0, 1'b0, 1'b1, '0);
        exp_q.delete();
        check("clr_count", 32'(count), 32'd0);
        check("clr_ovf", 32'(overflow), 32'd0);
        check("clr_unf", 32'(underflow), 32'd0);
        check("clr_rdv", 32'(rd_valid), 32'd0);
        check("clr_dout", 32'(data_out), 32'd2046);
        check("clr_max", 32'(max_level), 32'd0);

        // pass-through on empty
        drive(1'b1, 1'b1, 1'b0, W'(8'h3C));
        check("pass_rdv", 32'(rd_valid), 32'd1);
        check("pass_dout", 32'(data_out), 32'h3C);
        check("pass_count", 32'(count), 32'd0);
        check("pass_unf", 32'(underflow), 32'd0);

        // enable low: push ignored, rd_valid drops
        push    = 1'b1;
        data_in = W'(12'h123);
        @(posedge clk);
        #1;
        push = 1'b0;
        check("hold_count", 32'(count), 32'd0);
        check("hold_rdv", 32'(rd_valid), 32'd0);
        check("hold_dout", 32'(data_out), 32'h3C);

        // clear mid-run, push ignored under clear
        for (int i = 0; i < 10; i++) begin
            do_push(W'(100 + i));
        end
        check("mid_count", 32'(count), 32'd10);
        check("mid_top", 32'(top_data), 32'd109);
        drive(1'b1, 1'b0, 1'b1, W'(12'h777));
        exp_q.delete();
        check("mclr_count", 32'(count), 32'd0);
        check("mclr_empty", 32'(empty), 32'd1);
        check("mclr_top", 32'(top_data), 32'd0);
        check("mclr_ovf", 32'(overflow), 32'd0);

        // asynchronous reset between edges
        for (int i = 0; i < 3; i++) begin
            do_push(W'(500 + i));
        end
        check("pre_rst_count", 32'(count), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        exp_q.delete();
        check("arst_count", 32'(count), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_dout", 32'(data_out), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, '0);
        check("post_rst_unf", 32'(underflow), 32'd1);
        check("post_rst_rdv", 32'(rd_valid), 32'd0);
        drive(1'b0, 1'b0, 1'b1, '0);

        // watermark: push 7, pop 4, push 2
        for (int i = 0; i < 7; i++) begin
            do_push(W'(12'h300 + i));
        end
        for (int i = 0; i < 4; i++) begin
            do_pop("wm_pop");
        end
        do_push(W'(12'hA01));
        do_push(W'(12'hA02));
        check("wm_count", 32'(count), 32'd5);
        check("wm_top", 32'(top_data), 32'hA02);
        check("wm_max", 32'(max_level), WM_EN ? 32'd7 : 32'd0);
        drive(1'b0, 1'b0, 1'b1, '0);
        check("wm_clr_max", 32'(max_level), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
